// File: rtl/ads127l01_pkg.sv
// ---------------------------------------------------------------------------
// ads127l01_pkg
// Shared types and helpers for the ADS127L01 acquisition sequencer.
//   acq_state_t  : sequencer state encoding
//   DATA_W_DEF   : default ADC sample width
//   OUT_W_DEF    : default read-path word width
//   sext24to32   : sign-extends a 24-bit ADC code to a 32-bit word
// ---------------------------------------------------------------------------
package ads127l01_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int OUT_W_DEF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RST_PULSE = 3'd1,
    ST_RST_WAIT  = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_DONE      = 3'd5
  } acq_state_t;

  function automatic logic [31:0] sext24to32(input logic [23:0] code);
    return {{8{code[23]}}, code};
  endfunction

endpackage

// File: rtl/ads127l01_acq_ctrl_out_reg.sv
// ---------------------------------------------------------------------------
// ads_out_reg
// Single-entry valid/ready output register. A new word loads when the entry
// is empty or is being accepted in the same cycle; otherwise the incoming
// word is reported as dropped and the held word is left untouched.
// Ports:
//   aclk, aresetn : clock, async active-low reset
//   flush         : discard any held word (takes priority over load)
//   in_valid      : offered word, in_data carries it
//   in_load       : offered word is taken this cycle
//   in_drop       : offered word is lost this cycle
//   m_valid/m_data/m_ready : downstream handshake
// ---------------------------------------------------------------------------
module ads_out_reg
  import ads127l01_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [OUT_W-1:0] in_data,
  output logic             in_load,
  output logic             in_drop,
  output logic             m_valid,
  output logic [OUT_W-1:0] m_data,
  input  logic             m_ready
);

  logic             m_valid_r;
  logic [OUT_W-1:0] m_data_r;
  logic             accept_s;

  // Entry can take a new word when empty or when the held word leaves now
  always_comb begin
    accept_s = !m_valid_r || m_ready;
    in_load  = in_valid && accept_s;
    in_drop  = in_valid && !accept_s;
  end

  // Output entry: flush, load, drain or hold
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
    end else if (flush) begin
      m_valid_r <= 1'b0;
      m_data_r  <= m_data_r;
    end else if (in_load) begin
      m_valid_r <= 1'b1;
      m_data_r  <= in_data;
    end else if (m_ready) begin
      m_valid_r <= 1'b0;
      m_data_r  <= m_data_r;
    end else begin
      m_valid_r <= m_valid_r;
      m_data_r  <= m_data_r;
    end
  end

  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;

endmodule

// File: rtl/ads127l01_acq_ctrl.sv
// ---------------------------------------------------------------------------
// ads127l01_acq_ctrl
// Acquisition sequencer for the ADS127L01: on a rising edge of enable it
// pulses the ADC reset, waits, raises start, discards cfg_settle frames and
// then forwards cfg_block_len samples (or a continuous stream) sign-extended
// to OUT_W bits through a one-entry valid/ready register.
// Ports:
//   aclk, aresetn           : clock, async active-low reset
//   enable                  : GPIO run level; rising edge starts, low aborts
//   cfg_settle, cfg_block_len : run configuration, latched at start
//   s_valid, s_data         : decoded ADC frames
//   m_valid, m_data, m_ready: sample output handshake
//   adc_reset_n, adc_start  : ADC control pins
//   busy, done, overflow, sample_cnt : status for software
// ---------------------------------------------------------------------------
module ads127l01_acq_ctrl
  import ads127l01_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int OUT_W         = OUT_W_DEF,
  parameter int CNT_W         = 16,
  parameter int RST_PULSE_CYC = 8,
  parameter int RST_WAIT_CYC  = 64
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [CNT_W-1:0]  cfg_settle,
  input  logic [CNT_W-1:0]  cfg_block_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  output logic [OUT_W-1:0]  m_data,
  input  logic              m_ready,
  output logic              adc_reset_n,
  output logic              adc_start,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam int TMR_MAX = (RST_PULSE_CYC > RST_WAIT_CYC) ? RST_PULSE_CYC : RST_WAIT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(RST_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST  = TMR_W'(RST_WAIT_CYC - 1);

  acq_state_t       state_r;
  acq_state_t       state_nxt_s;
  logic             enable_q_r;
  logic             en_rise_s;
  logic             abort_s;
  logic             start_run_s;
  logic [TMR_W-1:0] tmr_r;
  logic [CNT_W-1:0] settle_cnt_r;
  logic [CNT_W-1:0] cfg_settle_r;
  logic [CNT_W-1:0] cfg_block_len_r;
  logic [CNT_W-1:0] sample_cnt_r;
  logic             overflow_r;
  logic             adc_reset_n_r;
  logic             adc_start_r;
  logic             busy_r;
  logic             done_r;
  logic             adc_reset_n_nxt_s;
  logic             adc_start_nxt_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic             fwd_valid_s;
  logic             load_s;
  logic             drop_s;
  logic [OUT_W-1:0] fwd_data_s;

  // Run-control decodes shared by the FSM and the counters
  always_comb begin
    en_rise_s   = enable && !enable_q_r;
    abort_s     = (state_r != ST_IDLE) && !enable;
    start_run_s = (state_r == ST_IDLE) && en_rise_s;
    // Frames only reach the output register while running and enabled
    fwd_valid_s = s_valid && (state_r == ST_RUN) && enable;
    fwd_data_s  = sext24to32(s_data);
  end

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; dropping enable overrides every other transition
  always_comb begin
    state_nxt_s = state_r;
    if (abort_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (en_rise_s) state_nxt_s = ST_RST_PULSE;
          else           state_nxt_s = ST_IDLE;
        end
        ST_RST_PULSE: begin
          if (tmr_r == PULSE_LAST) state_nxt_s = ST_RST_WAIT;
          else                     state_nxt_s = ST_RST_PULSE;
        end
        ST_RST_WAIT: begin
          if (tmr_r != WAIT_LAST)                state_nxt_s = ST_RST_WAIT;
          else if (cfg_settle_r == CNT_W'(0))    state_nxt_s = ST_RUN;
          else                                   state_nxt_s = ST_SETTLE;
        end
        ST_SETTLE: begin
          // The last settle frame is itself discarded; RUN starts after it
          if (s_valid && (settle_cnt_r == cfg_settle_r - CNT_W'(1))) state_nxt_s = ST_RUN;
          else                                                       state_nxt_s = ST_SETTLE;
        end
        ST_RUN: begin
          // Finish on the edge that loads the final sample of the block
          if (load_s && (cfg_block_len_r != CNT_W'(0)) &&
              (sample_cnt_r + CNT_W'(1) == cfg_block_len_r)) state_nxt_s = ST_DONE;
          else                                               state_nxt_s = ST_RUN;
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered pins track state_r
  always_comb begin
    adc_reset_n_nxt_s = 1'b1;
    adc_start_nxt_s   = 1'b0;
    busy_nxt_s        = 1'b0;
    done_nxt_s        = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        adc_reset_n_nxt_s = 1'b1;
      end
      ST_RST_PULSE: begin
        adc_reset_n_nxt_s = 1'b0;
        busy_nxt_s        = 1'b1;
      end
      ST_RST_WAIT: begin
        busy_nxt_s = 1'b1;
      end
      ST_SETTLE, ST_RUN: begin
        adc_start_nxt_s = 1'b1;
        busy_nxt_s      = 1'b1;
      end
      ST_DONE: begin
        done_nxt_s = 1'b1;
      end
      default: begin
        adc_reset_n_nxt_s = 1'b1;
      end
    endcase
  end

  // Registered control pins and status flags; ADC held in reset during aresetn
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      adc_reset_n_r <= 1'b0;
      adc_start_r   <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      adc_reset_n_r <= adc_reset_n_nxt_s;
      adc_start_r   <= adc_start_nxt_s;
      busy_r        <= busy_nxt_s;
      done_r        <= done_nxt_s;
    end
  end

  // Enable edge detector and reset-sequence timer (restarts on every state change)
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      enable_q_r <= 1'b0;
      tmr_r      <= '0;
    end else begin
      enable_q_r <= enable;
      if (state_nxt_s != state_r) tmr_r <= '0;
      else                        tmr_r <= tmr_r + TMR_W'(1);
    end
  end

  // Configuration latch and settle-frame counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_settle_r    <= '0;
      cfg_block_len_r <= '0;
      settle_cnt_r    <= '0;
    end else begin
      if (start_run_s) begin
        cfg_settle_r    <= cfg_settle;
        cfg_block_len_r <= cfg_block_len;
      end else begin
        cfg_settle_r    <= cfg_settle_r;
        cfg_block_len_r <= cfg_block_len_r;
      end
      if (state_r != ST_SETTLE)    settle_cnt_r <= '0;
      else if (s_valid && enable)  settle_cnt_r <= settle_cnt_r + CNT_W'(1);
      else                         settle_cnt_r <= settle_cnt_r;
    end
  end

  // Software-visible counters: cleared at run start, kept across abort/done
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sample_cnt_r <= '0;
      overflow_r   <= 1'b0;
    end else if (start_run_s) begin
      sample_cnt_r <= '0;
      overflow_r   <= 1'b0;
    end else begin
      if (load_s) sample_cnt_r <= sample_cnt_r + CNT_W'(1);
      else        sample_cnt_r <= sample_cnt_r;
      if (drop_s) overflow_r <= 1'b1;
      else        overflow_r <= overflow_r;
    end
  end

  ads_out_reg #(
    .OUT_W (OUT_W)
  ) u_out_reg (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .flush    (abort_s),
    .in_valid (fwd_valid_s),
    .in_data  (fwd_data_s),
    .in_load  (load_s),
    .in_drop  (drop_s),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready)
  );

  assign adc_reset_n = adc_reset_n_r;
  assign adc_start   = adc_start_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign overflow    = overflow_r;
  assign sample_cnt  = sample_cnt_r;

endmodule

// File: tb/tb_ads127l01_acq_ctrl.sv
// Directed bench: dut1 uses the default timing, dut2 uses CNT_W=4 and short
// reset timing for the counter wrap and async-reset cases.
module tb_ads127l01_acq_ctrl;

  logic        aclk;
  logic        aresetn;

  logic        enable;
  logic [15:0] cfg_settle;
  logic [15:0] cfg_block_len;
  logic        s_valid;
  logic [23:0] s_data;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic        adc_reset_n;
  logic        adc_start;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] sample_cnt;

  logic        enable2;
  logic [3:0]  cfg_settle2;
  logic [3:0]  cfg_block_len2;
  logic        s_valid2;
  logic [23:0] s_data2;
  logic        m_valid2;
  logic [31:0] m_data2;
  logic        m_ready2;
  logic        adc_reset_n2;
  logic        adc_start2;
  logic        busy2;
  logic        done2;
  logic        overflow2;
  logic [3:0]  sample_cnt2;

  int n_total;
  int n_bad;
  logic [31:0] got_q[$];

  ads127l01_acq_ctrl dut1 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .cfg_settle(cfg_settle), .cfg_block_len(cfg_block_len),
    .s_valid(s_valid), .s_data(s_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .adc_reset_n(adc_reset_n), .adc_start(adc_start),
    .busy(busy), .done(done), .overflow(overflow), .sample_cnt(sample_cnt)
  );

  ads127l01_acq_ctrl #(
    .CNT_W(4), .RST_PULSE_CYC(2), .RST_WAIT_CYC(4)
  ) dut2 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable2),
    .cfg_settle(cfg_settle2), .cfg_block_len(cfg_block_len2),
    .s_valid(s_valid2), .s_data(s_data2),
    .m_valid(m_valid2), .m_data(m_data2), .m_ready(m_ready2),
    .adc_reset_n(adc_reset_n2), .adc_start(adc_start2),
    .busy(busy2), .done(done2), .overflow(overflow2), .sample_cnt(sample_cnt2)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Record every word dut1 hands off (sampled mid-cycle, before the accepting edge)
  always @(negedge aclk) begin
    if (m_valid && m_ready) got_q.push_back(m_data);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input int which, input logic [23:0] d);
    if (which == 1) begin s_valid = 1'b1; s_data = d; end
    else begin s_valid2 = 1'b1; s_data2 = d; end
    tick();
    s_valid  = 1'b0;
    s_valid2 = 1'b0;
  endtask

  task automatic wait_start(input int which, input string tag);
    int guard;
    guard = 0;
    while (((which == 1) ? adc_start : adc_start2) == 1'b0 && guard < 200) begin
      guard++;
      tick();
    end
    check_val(tag, 32'((which == 1) ? adc_start : adc_start2), 32'd1);
  endtask

  // Return dut1 to IDLE, load a configuration and present a rising enable edge
  task automatic arm(input logic [15:0] settle, input logic [15:0] blk);
    enable = 1'b0;
    tick();
    tick();
    cfg_settle    = settle;
    cfg_block_len = blk;
    enable        = 1'b1;
    tick();
  endtask

  initial begin
    int cnt;
    logic [31:0] exp_w;
    n_total = 0;
    n_bad   = 0;
    aresetn = 1'b0;
    enable = 1'b0; cfg_settle = 16'd0; cfg_block_len = 16'd0;
    s_valid = 1'b0; s_data = 24'd0; m_ready = 1'b0;
    enable2 = 1'b0; cfg_settle2 = 4'd0; cfg_block_len2 = 4'd0;
    s_valid2 = 1'b0; s_data2 = 24'd0; m_ready2 = 1'b1;

    // Reset state
    tick(); tick();
    check_val("rst_adc_reset_n", 32'(adc_reset_n), 32'd0);
    check_val("rst_adc_start",   32'(adc_start),   32'd0);
    check_val("rst_m_valid",     32'(m_valid),     32'd0);
    check_val("rst_m_data",      m_data,           32'd0);
    check_val("rst_busy_done",   32'({busy, done, overflow}), 32'd0);
    check_val("rst_sample_cnt",  32'(sample_cnt),  32'd0);
    aresetn = 1'b1;
    tick();
    check_val("idle_adc_reset_n", 32'(adc_reset_n), 32'd1);
    check_val("idle_busy",        32'(busy),        32'd0);

    // Power-up sequence timing with settle=3, block=5
    cfg_settle = 16'd3; cfg_block_len = 16'd5; m_ready = 1'b1;
    enable = 1'b1;
    tick();
    cnt = 0;
    exp_w = 32'd1;
    while (adc_reset_n == 1'b0 && cnt < 100) begin
      if (busy !== 1'b1) exp_w = 32'd0;
      cnt++;
      tick();
    end
    check_val("pulse_len", 32'(cnt), 32'd8);
    cnt = 0;
    while (adc_start == 1'b0 && cnt < 200) begin
      if (busy !== 1'b1) exp_w = 32'd0;
      cnt++;
      tick();
    end
    check_val("wait_len", 32'(cnt), 32'd64);
    check_val("busy_in_seq", exp_w, 32'd1);

    // Settle then block: frames 1..3 dropped, 4..8 delivered
    got_q.delete();
    for (int i = 1; i <= 8; i++) begin
      send(1, 24'(i));
      if (i < 8) tick();
    end
    check_val("blk_done",       32'(done),       32'd1);
    check_val("blk_adc_start",  32'(adc_start),  32'd0);
    check_val("blk_sample_cnt", 32'(sample_cnt), 32'd5);
    check_val("blk_busy",       32'(busy),       32'd0);
    tick();
    send(1, 24'd9);
    tick(); tick();
    check_val("done_no_ovf", 32'(overflow), 32'd0);
    check_val("blk_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) check_val("blk_word", got_q[i], 32'(i + 4));
    end

    // Sign extension and same-cycle load/accept, continuous mode
    arm(16'd0, 16'd0);
    wait_start(1, "sx_start");
    m_ready = 1'b0;
    send(1, 24'h800001);
    check_val("sx_neg", m_data, 32'hFF800001);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    send(1, 24'h7FFFFF);
    check_val("sx_pos", m_data, 32'h007FFFFF);
    m_ready = 1'b1; tick();
    s_valid = 1'b1; s_data = 24'h000011; tick();
    s_data = 24'h000022; tick();
    s_valid = 1'b0;
    check_val("b2b_data",     m_data,            32'h00000022);
    check_val("b2b_overflow", 32'(overflow),     32'd0);
    check_val("b2b_cnt",      32'(sample_cnt),   32'd4);
    tick();

    // Back-pressure: second frame dropped while first is held
    arm(16'd0, 16'd0);
    wait_start(1, "bp_start");
    m_ready = 1'b0;
    send(1, 24'h000010);
    tick();
    send(1, 24'h000020);
    check_val("bp_valid",    32'(m_valid),    32'd1);
    check_val("bp_data",     m_data,          32'h00000010);
    check_val("bp_overflow", 32'(overflow),   32'd1);
    check_val("bp_cnt",      32'(sample_cnt), 32'd1);

    // Abort with a pending word
    enable = 1'b0;
    tick();
    check_val("ab_valid", 32'(m_valid),    32'd0);
    check_val("ab_start", 32'(adc_start),  32'd0);
    check_val("ab_busy",  32'(busy),       32'd0);
    check_val("ab_cnt",   32'(sample_cnt), 32'd1);
    check_val("ab_ovf",   32'(overflow),   32'd1);

    // Next run clears the sticky flag and counter
    arm(16'd0, 16'd0);
    check_val("rerun_ovf",   32'(overflow),    32'd0);
    check_val("rerun_cnt",   32'(sample_cnt),  32'd0);
    check_val("rerun_rstn",  32'(adc_reset_n), 32'd0);
    enable = 1'b0;
    tick();

    // Continuous wrap on the 4-bit counter
    enable2 = 1'b1;
    tick();
    wait_start(2, "wr_start");
    for (int k = 1; k <= 17; k++) begin
      send(2, 24'(k));
      check_val("wr_cnt", 32'(sample_cnt2), 32'(k % 16));
      tick();
    end
    check_val("wr_done",  32'(done2),      32'd0);
    check_val("wr_start_hold", 32'(adc_start2), 32'd1);

    // Async reset mid-run takes effect without a clock edge
    #2;
    aresetn = 1'b0;
    #1;
    check_val("ar_start", 32'(adc_start2),   32'd0);
    check_val("ar_rstn",  32'(adc_reset_n2), 32'd0);
    check_val("ar_cnt",   32'(sample_cnt2),  32'd0);
    check_val("ar_busy",  32'(busy2),        32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
